trsig_monitor: RTL

//  Conflict monitor between the two-road signal controller (trsig) and the lamp drivers.

---
 rtl/trsig_monitor.sv | 207 ++++++++++++++++++++
 1 files changed

// File: rtl/trsig_monitor.sv
// trsig_monitor: conflict monitor between the trsig controller and the lamp drivers.
// Legal light vectors pass with one cycle latency; the first violation latches flashing red.
module trsig_monitor #(
    parameter int MIN_YEL   = 3,
    parameter int MAX_PHASE = 64,
    parameter int FLASH_DIV = 8
) (
    input  logic       clk,
    input  logic       rst,
    input  logic       reda,
    input  logic       redb,
    input  logic       yela,
    input  logic       yelb,
    input  logic       grna,
    input  logic       grnb,
    output logic       lamp_reda,
    output logic       lamp_redb,
    output logic       lamp_yela,
    output logic       lamp_yelb,
    output logic       lamp_grna,
    output logic       lamp_grnb,
    output logic       fault,
    output logic [2:0] fault_code
);

    localparam int YW = $clog2(MIN_YEL + 1);
    localparam int SW = $clog2(MAX_PHASE + 1);
    localparam int FW = $clog2(2 * FLASH_DIV);

    localparam logic [YW-1:0] YEL_MAX  = YW'(MIN_YEL);
    localparam logic [SW-1:0] SAME_MAX = SW'(MAX_PHASE);
    localparam logic [FW-1:0] FL_HALF  = FW'(FLASH_DIV);
    localparam logic [FW-1:0] FL_LAST  = FW'(2 * FLASH_DIV - 1);

    localparam logic [2:0] C_NONE      = 3'd0;
    localparam logic [2:0] C_ILLEGAL   = 3'd1;
    localparam logic [2:0] C_CONFLICT  = 3'd2;
    localparam logic [2:0] C_SEQUENCE  = 3'd3;
    localparam logic [2:0] C_SHORT_YEL = 3'd4;
    localparam logic [2:0] C_WATCHDOG  = 3'd5;

    localparam logic [2:0] ROAD_RED = 3'b100;

    typedef enum logic {
        S_PASS,
        S_FAULT
    } state_t;

    state_t r_state;
    state_t w_state_nxt;

    // Each road is packed as {red, yel, grn}.
    logic [2:0]    w_a;
    logic [2:0]    w_b;
    logic [2:0]    r_lamp_a;
    logic [2:0]    r_lamp_b;
    logic [2:0]    r_prev_a;
    logic [2:0]    r_prev_b;
    logic          r_pv;
    logic          r_fault;
    logic [2:0]    r_code;
    logic [2:0]    w_code;
    logic [YW-1:0] r_ycnt_a;
    logic [YW-1:0] r_ycnt_b;
    logic [YW-1:0] w_ycnt_a;
    logic [YW-1:0] w_ycnt_b;
    logic [SW-1:0] r_same;
    logic [SW-1:0] w_same;
    logic [FW-1:0] r_flash;
    logic [FW-1:0] w_flash;
    logic          w_flash_on;
    logic          w_ill;
    logic          w_conf;
    logic          w_seq;
    logic          w_short;
    logic          w_wdog;

    function automatic logic onehot3(input logic [2:0] v);
        return (v == 3'b100) || (v == 3'b010) || (v == 3'b001);
    endfunction

    function automatic logic bad_seq(input logic [2:0] p,
                                     input logic [2:0] c);
        return (p[0] & c[2]) | (p[2] & c[1]) | (p[1] & c[0]);
    endfunction

    function automatic logic short_yel(input logic [2:0]    p,
                                       input logic [2:0]    c,
                                       input logic [YW-1:0] n);
        return p[1] & c[2] & (n < YEL_MAX);
    endfunction

    assign w_a = {reda, yela, grna};
    assign w_b = {redb, yelb, grnb};

    assign w_ycnt_a = !w_a[1] ? '0 :
                      (r_ycnt_a == YEL_MAX) ? YEL_MAX :
                      r_ycnt_a + 1'b1;
    assign w_ycnt_b = !w_b[1] ? '0 :
                      (r_ycnt_b == YEL_MAX) ? YEL_MAX :
                      r_ycnt_b + 1'b1;

    // The first sample after reset has no predecessor, so its run length is 0.
    assign w_same = !(r_pv && ({w_a, w_b} == {r_prev_a, r_prev_b})) ? '0 :
                    (r_same == SAME_MAX) ? SAME_MAX :
                    r_same + 1'b1;

    assign w_ill   = !onehot3(w_a) || !onehot3(w_b);
    assign w_conf  = (w_a[1] | w_a[0]) & (w_b[1] | w_b[0]);
    assign w_seq   = r_pv & (bad_seq(r_prev_a, w_a) | bad_seq(r_prev_b, w_b));
    assign w_short = r_pv & (short_yel(r_prev_a, w_a, r_ycnt_a) |
                             short_yel(r_prev_b, w_b, r_ycnt_b));
    assign w_wdog  = (w_same == SAME_MAX);

    always_comb begin
        w_code = C_NONE;
        if (w_ill) begin
            w_code = C_ILLEGAL;
        end else if (w_conf) begin
            w_code = C_CONFLICT;
        end else if (w_seq) begin
            w_code = C_SEQUENCE;
        end else if (w_short) begin
            w_code = C_SHORT_YEL;
        end else if (w_wdog) begin
            w_code = C_WATCHDOG;
        end
    end

    always_comb begin
        w_state_nxt = r_state;
        case (r_state)
            S_PASS: begin
                if (w_code != C_NONE) begin
                    w_state_nxt = S_FAULT;
                end
            end
            S_FAULT: begin
                w_state_nxt = S_FAULT;
            end
            default: begin
                w_state_nxt = S_PASS;
            end
        endcase
    end

    assign w_flash    = (r_flash == FL_LAST) ? '0 : r_flash + 1'b1;
    assign w_flash_on = (w_flash < FL_HALF);

    always_ff @(posedge clk) begin
        if (rst) begin
            r_state  <= S_PASS;
            r_lamp_a <= ROAD_RED;
            r_lamp_b <= ROAD_RED;
            r_prev_a <= '0;
            r_prev_b <= '0;
            r_pv     <= 1'b0;
            r_fault  <= 1'b0;
            r_code   <= C_NONE;
            r_ycnt_a <= '0;
            r_ycnt_b <= '0;
            r_same   <= '0;
            r_flash  <= '0;
        end else begin
            r_state <= w_state_nxt;
            case (r_state)
                S_PASS: begin
                    if (w_code != C_NONE) begin
                        r_fault  <= 1'b1;
                        r_code   <= w_code;
                        r_lamp_a <= ROAD_RED;
                        r_lamp_b <= ROAD_RED;
                        r_flash  <= '0;
                    end else begin
                        r_lamp_a <= w_a;
                        r_lamp_b <= w_b;
                        r_prev_a <= w_a;
                        r_prev_b <= w_b;
                        r_pv     <= 1'b1;
                        r_ycnt_a <= w_ycnt_a;
                        r_ycnt_b <= w_ycnt_b;
                        r_same   <= w_same;
                    end
                end
                S_FAULT: begin
                    r_flash  <= w_flash;
                    r_lamp_a <= {w_flash_on, 2'b00};
                    r_lamp_b <= {w_flash_on, 2'b00};
                end
                default: begin
                    r_lamp_a <= ROAD_RED;
                    r_lamp_b <= ROAD_RED;
                end
            endcase
        end
    end

    assign lamp_reda  = r_lamp_a[2];
    assign lamp_yela  = r_lamp_a[1];
    assign lamp_grna  = r_lamp_a[0];
    assign lamp_redb  = r_lamp_b[2];
    assign lamp_yelb  = r_lamp_b[1];
    assign lamp_grnb  = r_lamp_b[0];
    assign fault      = r_fault;
    assign fault_code = r_code;

endmodule
